attack_responder: RTL and testbench

- Defender-side board for the naval battle game: holds the ship placement map and answers incoming attack coordinates with a 2-bit status code.
- The status code uses the same encoding the attacker's status decoder consumes on its 2-bit status input.
- Sits between the placement/attack switch inputs and the display path; exports cell maps for the 5x7 LED matrix driver.

---
 rtl/attack_responder.sv | 140 ++++++++++++++
 tb/tb_attack_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/attack_responder.sv
// Defender board: stores ship placement, answers attacks with a 2-bit status, tracks win/loss.
// Latency: status valid the cycle after acceptance; accepts one attack per 2 cycles (ready low while responding).
module attack_responder #(
    parameter int COLS      = 5,
    parameter int ROWS      = 7,
    parameter int MAX_SHOTS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 place_en,
    input  logic [2:0]           place_row,
    input  logic [2:0]           place_col,
    input  logic                 lock,
    input  logic                 attack_valid,
    input  logic [2:0]           attack_row,
    input  logic [2:0]           attack_col,
    output logic                 attack_ready,
    output logic                 status_valid,
    output logic [1:0]           status,
    output logic [5:0]           hits,
    output logic [5:0]           ship_cells,
    output logic [5:0]           shots_left,
    output logic                 game_won,
    output logic                 game_lost,
    output logic [1:0]           phase,
    output logic [ROWS*COLS-1:0] ship_map,
    output logic [ROWS*COLS-1:0] hit_map
);
    localparam int CELLS = ROWS * COLS;
    localparam int IW    = $clog2(CELLS);

    typedef enum logic [1:0] {
        SETUP   = 2'b00,
        ARMED   = 2'b01,
        RESPOND = 2'b10,
        OVER    = 2'b11
    } phase_e;

    localparam logic [1:0] ST_MISS    = 2'b00;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_REPEAT  = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    phase_e             phase_q;
    logic [CELLS-1:0]   ship_map_q, hit_map_q;
    logic [5:0]         hits_q, ship_cells_q, shots_left_q;
    logic [1:0]         status_q;
    logic               status_vld_q, won_q, lost_q;

    logic               p_vld, a_vld, p_new;
    logic [IW-1:0]      p_idx, a_idx;
    logic [CELLS-1:0]   p_bit, a_bit;
    logic [5:0]         ship_cells_d;

    always_comb begin
        p_vld = (32'(place_row) < ROWS) && (32'(place_col) < COLS);
        a_vld = (32'(attack_row) < ROWS) && (32'(attack_col) < COLS);
        p_idx = IW'(32'(place_row) * COLS + 32'(place_col));
        a_idx = IW'(32'(attack_row) * COLS + 32'(attack_col));
        // Out-of-range coordinates map to an empty mask so they never touch the maps
        p_bit = p_vld ? (CELLS'(1) << p_idx) : '0;
        a_bit = a_vld ? (CELLS'(1) << a_idx) : '0;
        p_new = place_en && |(p_bit & ~ship_map_q);
        ship_cells_d = ship_cells_q + {5'd0, p_new};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= SETUP;
            ship_map_q   <= '0;
            hit_map_q    <= '0;
            hits_q       <= '0;
            ship_cells_q <= '0;
            shots_left_q <= 6'(MAX_SHOTS);
            status_q     <= ST_MISS;
            status_vld_q <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            status_vld_q <= 1'b0;
            case (phase_q)
                SETUP: begin
                    if (place_en) begin
                        ship_map_q <= ship_map_q | p_bit;
                    end
                    ship_cells_q <= ship_cells_d;
                    if (lock && ship_cells_d != 6'd0) begin
                        phase_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (attack_valid) begin
                        status_vld_q <= 1'b1;
                        phase_q      <= RESPOND;
                        if (!a_vld) begin
                            status_q <= ST_INVALID;
                        end else if (|(hit_map_q & a_bit)) begin
                            status_q <= ST_REPEAT;
                        end else begin
                            hit_map_q    <= hit_map_q | a_bit;
                            shots_left_q <= shots_left_q - 6'd1;
                            if (|(ship_map_q & a_bit)) begin
                                status_q <= ST_HIT;
                                hits_q   <= hits_q + 6'd1;
                            end else begin
                                status_q <= ST_MISS;
                            end
                        end
                    end
                end
                RESPOND: begin
                    // Win is checked first so a hit on the final shot counts as a win
                    if (hits_q == ship_cells_q) begin
                        phase_q <= OVER;
                        won_q   <= 1'b1;
                    end else if (shots_left_q == 6'd0) begin
                        phase_q <= OVER;
                        lost_q  <= 1'b1;
                    end else begin
                        phase_q <= ARMED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign attack_ready = (phase_q == ARMED);
    assign status_valid = status_vld_q;
    assign status       = status_q;
    assign hits         = hits_q;
    assign ship_cells   = ship_cells_q;
    assign shots_left   = shots_left_q;
    assign game_won     = won_q;
    assign game_lost    = lost_q;
    assign phase        = phase_q;
    assign ship_map     = ship_map_q;
    assign hit_map      = hit_map_q;
endmodule

// File: tb/tb_attack_responder.sv
// Scenario bench for attack_responder; expected status codes go through a queue checked on each status pulse.
module tb_attack_responder;
    logic        clk, rst_n;
    logic        place_en, lock, attack_valid;
    logic [2:0]  place_row, place_col, attack_row, attack_col;
    logic        attack_ready, status_valid, game_won, game_lost;
    logic [1:0]  status, phase;
    logic [5:0]  hits, ship_cells, shots_left;
    logic [34:0] ship_map, hit_map;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    logic prev_sv = 1'b0;
    logic [1:0] exp_q[$];

    attack_responder #(.COLS(5), .ROWS(7), .MAX_SHOTS(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .place_en(place_en), .place_row(place_row), .place_col(place_col),
        .lock(lock),
        .attack_valid(attack_valid), .attack_row(attack_row), .attack_col(attack_col),
        .attack_ready(attack_ready), .status_valid(status_valid), .status(status),
        .hits(hits), .ship_cells(ship_cells), .shots_left(shots_left),
        .game_won(game_won), .game_lost(game_lost), .phase(phase),
        .ship_map(ship_map), .hit_map(hit_map)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every status pulse must match the oldest expectation and last one cycle
    always @(negedge clk) begin
        if (rst_n && status_valid) begin
            pulse_cnt++;
            vectors++;
            if (prev_sv) begin
                miscompares++;
                $display("FAIL status_valid_width: high on consecutive cycles, required single-cycle pulse");
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL status_unexpected: got status=%b with no pending attack", status);
            end else begin
                automatic logic [1:0] e = exp_q.pop_front();
                if (status !== e) begin
                    miscompares++;
                    $display("FAIL status_code: got %b required %b", status, e);
                end
            end
        end
        prev_sv = status_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input logic [2:0] r, input logic [2:0] c);
        place_en = 1'b1; place_row = r; place_col = c;
        tick();
        place_en = 1'b0;
    endtask

    task automatic do_lock();
        lock = 1'b1;
        tick();
        lock = 1'b0;
    endtask

    task automatic fire(input logic [2:0] r, input logic [2:0] c, input logic [1:0] exp_st);
        exp_q.push_back(exp_st);
        attack_valid = 1'b1; attack_row = r; attack_col = c;
        tick();
        attack_valid = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        place_en = 0; lock = 0; attack_valid = 0;
        place_row = 0; place_col = 0; attack_row = 0; attack_col = 0;
        #2 rst_n = 1'b0;
        tick();
        vectors++; if (phase !== 2'b00) begin miscompares++; $display("FAIL reset_phase: got %b required 00", phase); end
        vectors++; if (shots_left !== 6'd20) begin miscompares++; $display("FAIL reset_shots: got %0d required 20", shots_left); end
        vectors++; if (hits !== 6'd0 || ship_cells !== 6'd0) begin miscompares++; $display("FAIL reset_counts: hits=%0d cells=%0d required 0 0", hits, ship_cells); end
        vectors++; if ({attack_ready, status_valid, status, game_won, game_lost} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got rdy=%b sv=%b st=%b won=%b lost=%b required all 0", attack_ready, status_valid, status, game_won, game_lost); end
        vectors++; if (ship_map !== '0 || hit_map !== '0) begin miscompares++; $display("FAIL reset_maps: ship=%h hit=%h required 0", ship_map, hit_map); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_place_lock();
        place(3'd0, 3'd0);
        place(3'd0, 3'd1);
        place(3'd1, 3'd4);
        vectors++; if (ship_cells !== 6'd3 || phase !== 2'b00) begin miscompares++; $display("FAIL place_count: cells=%0d phase=%b required 3 00", ship_cells, phase); end
        do_lock();
        vectors++; if (phase !== 2'b01 || attack_ready !== 1'b1) begin miscompares++; $display("FAIL lock_armed: phase=%b rdy=%b required 01 1", phase, attack_ready); end
        vectors++; if (ship_map !== 35'h0_0000_0203) begin miscompares++; $display("FAIL ship_map: got %h required 000000203", ship_map); end
    endtask

    task automatic test_hit_miss();
        fire(3'd0, 3'd0, 2'b01);
        vectors++; if (hits !== 6'd1 || shots_left !== 6'd19) begin miscompares++; $display("FAIL hit_counts: hits=%0d shots=%0d required 1 19", hits, shots_left); end
        vectors++; if (status !== 2'b01) begin miscompares++; $display("FAIL status_hold: got %b required 01", status); end
        fire(3'd6, 3'd4, 2'b00);
        vectors++; if (hits !== 6'd1 || shots_left !== 6'd18) begin miscompares++; $display("FAIL miss_counts: hits=%0d shots=%0d required 1 18", hits, shots_left); end
        vectors++; if (hit_map !== 35'h4_0000_0001) begin miscompares++; $display("FAIL hit_map: got %h required 400000001", hit_map); end
    endtask

    task automatic test_repeat_invalid();
        fire(3'd0, 3'd0, 2'b10);
        vectors++; if (hits !== 6'd1 || shots_left !== 6'd18) begin miscompares++; $display("FAIL repeat_counts: hits=%0d shots=%0d required 1 18", hits, shots_left); end
        fire(3'd7, 3'd0, 2'b11);
        fire(3'd2, 3'd5, 2'b11);
        vectors++; if (hits !== 6'd1 || shots_left !== 6'd18 || hit_map !== 35'h4_0000_0001) begin miscompares++; $display("FAIL invalid_state: hits=%0d shots=%0d hit_map=%h required 1 18 400000001", hits, shots_left, hit_map); end
        vectors++; if (phase !== 2'b01) begin miscompares++; $display("FAIL invalid_phase: got %b required 01", phase); end
    endtask

    task automatic test_back_to_back();
        int pulses_before;
        exp_q.push_back(2'b01);
        attack_valid = 1'b1; attack_row = 3'd0; attack_col = 3'd1;
        tick();
        vectors++; if (attack_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_respond1: got %b required 0", attack_ready); end
        attack_row = 3'd1; attack_col = 3'd4;
        exp_q.push_back(2'b01);
        tick();
        vectors++; if (attack_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_armed: got %b required 1", attack_ready); end
        tick();
        vectors++; if (attack_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_respond2: got %b required 0", attack_ready); end
        attack_row = 3'd2; attack_col = 3'd2;
        tick();
        vectors++; if (game_won !== 1'b1 || game_lost !== 1'b0 || phase !== 2'b11) begin miscompares++; $display("FAIL win: won=%b lost=%b phase=%b required 1 0 11", game_won, game_lost, phase); end
        vectors++; if (hits !== 6'd3 || shots_left !== 6'd16) begin miscompares++; $display("FAIL win_counts: hits=%0d shots=%0d required 3 16", hits, shots_left); end
        pulses_before = pulse_cnt;
        place_en = 1'b1; lock = 1'b1;
        repeat (4) tick();
        attack_valid = 1'b0; place_en = 1'b0; lock = 1'b0;
        vectors++; if (pulse_cnt !== pulses_before || attack_ready !== 1'b0 || game_won !== 1'b1 || ship_cells !== 6'd3) begin miscompares++; $display("FAIL over_ignores: pulses=%0d->%0d rdy=%b won=%b cells=%0d required no pulse 0 1 3", pulses_before, pulse_cnt, attack_ready, game_won, ship_cells); end
    endtask

    task automatic test_loss();
        apply_reset();
        do_lock();
        vectors++; if (phase !== 2'b00) begin miscompares++; $display("FAIL empty_lock: phase=%b required 00", phase); end
        place(3'd7, 3'd0);
        vectors++; if (ship_cells !== 6'd0 || ship_map !== '0) begin miscompares++; $display("FAIL invalid_place: cells=%0d map=%h required 0 0", ship_cells, ship_map); end
        place_en = 1'b1; place_row = 3'd0; place_col = 3'd0; lock = 1'b1;
        tick();
        place_en = 1'b0; lock = 1'b0;
        vectors++; if (phase !== 2'b01 || ship_cells !== 6'd1) begin miscompares++; $display("FAIL place_and_lock: phase=%b cells=%0d required 01 1", phase, ship_cells); end
        for (int i = 1; i <= 20; i++) fire(3'(i / 5), 3'(i % 5), 2'b00);
        vectors++; if (game_lost !== 1'b1 || game_won !== 1'b0 || phase !== 2'b11) begin miscompares++; $display("FAIL loss: lost=%b won=%b phase=%b required 1 0 11", game_lost, game_won, phase); end
        vectors++; if (shots_left !== 6'd0 || hits !== 6'd0) begin miscompares++; $display("FAIL loss_counts: shots=%0d hits=%0d required 0 0", shots_left, hits); end
    endtask

    task automatic test_last_shot_win();
        apply_reset();
        place(3'd3, 3'd2);
        place(3'd3, 3'd2);
        vectors++; if (ship_cells !== 6'd1) begin miscompares++; $display("FAIL dup_place: cells=%0d required 1", ship_cells); end
        do_lock();
        for (int i = 0; i < 19; i++) begin
            automatic int idx = (i < 15) ? 20 + i : i - 15;
            fire(3'(idx / 5), 3'(idx % 5), 2'b00);
        end
        vectors++; if (shots_left !== 6'd1 || phase !== 2'b01) begin miscompares++; $display("FAIL before_last: shots=%0d phase=%b required 1 01", shots_left, phase); end
        fire(3'd3, 3'd2, 2'b01);
        vectors++; if (game_won !== 1'b1 || game_lost !== 1'b0 || shots_left !== 6'd0) begin miscompares++; $display("FAIL last_shot_win: won=%b lost=%b shots=%0d required 1 0 0", game_won, game_lost, shots_left); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        place(3'd1, 3'd1);
        do_lock();
        fire(3'd5, 3'd0, 2'b00);
        rst_n = 1'b0;
        #1;
        vectors++; if (phase !== 2'b00 || attack_ready !== 1'b0 || shots_left !== 6'd20) begin miscompares++; $display("FAIL midreset_state: phase=%b rdy=%b shots=%0d required 00 0 20", phase, attack_ready, shots_left); end
        vectors++; if (ship_map !== '0 || hit_map !== '0 || ship_cells !== 6'd0 || status !== 2'b00) begin miscompares++; $display("FAIL midreset_data: ship=%h hit=%h cells=%0d st=%b required 0 0 0 00", ship_map, hit_map, ship_cells, status); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_place_lock();
        test_hit_miss();
        test_repeat_invalid();
        test_back_to_back();
        test_loss();
        test_last_shot_win();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_status: %0d expected responses never produced, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
